// File: rtl/codificador_varredura_if.sv
// Handshake and status bundle for the 8-to-3 row encoder.
// The bench or upstream logic uses the master side; the encoder uses the slave side.
interface codificador_varredura_if;
  logic       nen;
  logic       load;
  logic [7:0] row_req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] addr;
  logic       busy;
  logic [3:0] count;

  modport master (
    output nen, load, row_req, out_ready,
    input  out_valid, addr, busy, count
  );

  modport slave (
    input  nen, load, row_req, out_ready,
    output out_valid, addr, busy, count
  );
endinterface

// File: rtl/codificador_varredura.sv
// Sequential 8-to-3 row encoder: captures a row-select vector and emits the
// address (k+1) mod 8 of each set bit, lowest bit first, over valid/ready.
module codificador_varredura (
  input  logic                   clk,
  input  logic                   rst_n,
  codificador_varredura_if.slave vr
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  logic [0:0] state_r;
  logic [0:0] state_s;
  logic [7:0] pend_r;
  logic [7:0] pend_s;
  logic [7:0] pend_left_s;
  logic       out_valid_r;
  logic       out_valid_s;
  logic [2:0] addr_r;
  logic [2:0] addr_s;
  logic       busy_r;
  logic [3:0] count_r;
  logic [3:0] count_s;
  logic       xfer_s;

  // Address of the lowest set bit; bit 7 wraps to address 0 through truncation.
  function automatic logic [2:0] code_lowest(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx + 3'd1;
  endfunction

  // Next-state logic for capture, transfer, pause and resume.
  always_comb begin
    state_s     = state_r;
    pend_s      = pend_r;
    out_valid_s = out_valid_r;
    addr_s      = addr_r;
    count_s     = count_r;
    xfer_s      = out_valid_r & vr.out_ready;
    // The presented word is always the lowest pending bit, so clearing it is pend & (pend-1).
    pend_left_s = pend_r & (pend_r - 8'd1);

    case (state_r)
      ST_IDLE: begin
        if (vr.load && !vr.nen) begin
          pend_s  = vr.row_req;
          count_s = 4'd0;
          if (vr.row_req != 8'd0) begin
            state_s     = ST_SERVE;
            out_valid_s = 1'b1;
            addr_s      = code_lowest(vr.row_req);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (xfer_s) begin
          pend_s  = pend_left_s;
          count_s = (count_r == 4'd8) ? count_r : count_r + 4'd1;
          if (pend_left_s == 8'd0) begin
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
          end else if (!vr.nen) begin
            out_valid_s = 1'b1;
            addr_s      = code_lowest(pend_left_s);
          end else begin
            out_valid_s = 1'b0;
          end
        end else if (!out_valid_r && !vr.nen && (pend_r != 8'd0)) begin
          out_valid_s = 1'b1;
          addr_s      = code_lowest(pend_r);
        end else begin
          out_valid_s = out_valid_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        pend_s      = 8'd0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pend_r      <= 8'd0;
      out_valid_r <= 1'b0;
      addr_r      <= 3'd0;
      busy_r      <= 1'b0;
      count_r     <= 4'd0;
    end else begin
      state_r     <= state_s;
      pend_r      <= pend_s;
      out_valid_r <= out_valid_s;
      addr_r      <= addr_s;
      busy_r      <= (state_s == ST_SERVE);
      count_r     <= count_s;
    end
  end

  assign vr.out_valid = out_valid_r;
  assign vr.addr      = addr_r;
  assign vr.busy      = busy_r;
  assign vr.count     = count_r;

endmodule

// File: tb/tb_codificador_varredura.sv
// Directed self-checking bench for codificador_varredura.
module tb_codificador_varredura;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  codificador_varredura_if vr ();

  codificador_varredura dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vr    (vr.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference row decoder: address a selects row (a+7) mod 8.
  function automatic logic [7:0] row_dec(input logic [2:0] a, input logic en);
    logic [2:0] r;
    r = a - 3'd1;
    return en ? (8'd1 << r) : 8'd0;
  endfunction

  logic       ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [2:0] exp_bp    [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    int         idx;
    logic [2:0] held;
    logic       was_stall;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    vr.nen       = 1'b0;
    vr.load      = 1'b0;
    vr.row_req   = 8'h00;
    vr.out_ready = 1'b0;
    #12;
    check_value("rst_outputs", {vr.out_valid, vr.addr, vr.busy, vr.count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic capture
    vr.row_req = 8'b1000_0101; vr.load = 1'b1; vr.out_ready = 1'b1;
    step(); vr.load = 1'b0;
    check_value("basic_w0", {vr.out_valid, vr.busy, vr.addr, vr.count}, {1'b1, 1'b1, 3'd1, 4'd0});
    step();
    check_value("basic_w1", {vr.out_valid, vr.addr, vr.count}, {1'b1, 3'd3, 4'd1});
    step();
    check_value("basic_w2", {vr.out_valid, vr.addr, vr.count}, {1'b1, 3'd0, 4'd2});
    step();
    check_value("basic_end", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b0, 4'd3});

    // Backpressure on a full vector
    vr.row_req = 8'hFF; vr.load = 1'b1; vr.out_ready = 1'b0;
    step(); vr.load = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      vr.out_ready = ready_pat[c % 4];
      if (vr.out_valid && vr.out_ready) begin
        check_value("bp_addr", vr.addr, exp_bp[idx]);
        idx++;
      end
      held      = vr.addr;
      was_stall = vr.out_valid && !vr.out_ready;
      step();
      if (was_stall) check_value("bp_hold", {vr.out_valid, vr.addr}, {1'b1, held});
    end
    check_value("bp_words", idx, 32'd8);
    check_value("bp_end", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b0, 4'd8});

    // Pause with nen
    vr.row_req = 8'b0011_0000; vr.load = 1'b1; vr.out_ready = 1'b0;
    step(); vr.load = 1'b0;
    check_value("pause_first", {vr.out_valid, vr.addr}, {1'b1, 3'd5});
    vr.nen = 1'b1;
    step();
    check_value("pause_hold", {vr.out_valid, vr.addr}, {1'b1, 3'd5});
    vr.out_ready = 1'b1;
    step();
    check_value("pause_withheld", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b1, 4'd1});
    vr.nen = 1'b0;
    step();
    check_value("pause_resume", {vr.out_valid, vr.addr, vr.count}, {1'b1, 3'd6, 4'd1});
    step();
    check_value("pause_end", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b0, 4'd2});

    // Blocked, empty and in-burst captures
    vr.nen = 1'b1; vr.row_req = 8'h0F; vr.load = 1'b1;
    step();
    check_value("blocked_load", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b0, 4'd2});
    vr.nen = 1'b0; vr.row_req = 8'h00;
    step();
    check_value("empty_load", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b0, 4'd0});
    vr.row_req = 8'h06; vr.out_ready = 1'b0;
    step();
    check_value("serve_load_w0", {vr.out_valid, vr.addr}, {1'b1, 3'd2});
    vr.row_req = 8'hFF; vr.out_ready = 1'b1;
    step();
    check_value("serve_load_w1", {vr.out_valid, vr.addr, vr.count}, {1'b1, 3'd3, 4'd1});
    step(); vr.load = 1'b0;
    check_value("serve_load_end", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b0, 4'd2});

    // Asynchronous reset mid-burst
    vr.row_req = 8'hF0; vr.load = 1'b1;
    step(); vr.load = 1'b0;
    check_value("ar_w0", {vr.out_valid, vr.addr}, {1'b1, 3'd5});
    step();
    step();
    check_value("ar_w2", {vr.out_valid, vr.addr, vr.count}, {1'b1, 3'd7, 4'd2});
    #2 rst_n = 1'b0;
    #1;
    check_value("ar_outputs", {vr.out_valid, vr.addr, vr.busy, vr.count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vr.row_req = 8'h01; vr.load = 1'b1;
    step(); vr.load = 1'b0;
    check_value("ar_new_w0", {vr.out_valid, vr.addr, vr.busy}, {1'b1, 3'd1, 1'b1});
    step();
    check_value("ar_new_end", {vr.out_valid, vr.busy, vr.count}, {1'b0, 1'b0, 4'd1});

    // Round trip through a row decoder for every single-bit vector
    for (int k = 0; k < 8; k++) begin
      vr.row_req = 8'd1 << k; vr.load = 1'b1;
      step(); vr.load = 1'b0;
      check_value("roundtrip", {vr.out_valid, row_dec(vr.addr, vr.out_valid)}, {1'b1, vr.row_req});
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
